// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl
// Controller for the 64x16 synchronous FIFO storage block. The storage takes
// externally supplied addresses, so this block owns the write/read pointers,
// the occupancy count and the storage enables.
//
// Two producers are arbitrated round-robin onto the single storage write port.
// The consumer side is a valid/ready port that hides the storage's
// one-cycle registered read latency.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req0_valid/data/ready      requester 0 write handshake
//   req1_valid/data/ready      requester 1 write handshake
//   m_valid/m_data/m_ready     read port towards the consumer
//   st_wr_en/addr/data         storage write port
//   st_rd_en/addr              storage read request
//   st_rd_data                 storage registered read data
//   level                      entries held in storage, not yet read out
module fifo_arb_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,

    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,

    output logic                  st_wr_en,
    output logic [AW-1:0]         st_wr_addr,
    output logic [DATA_WIDTH-1:0] st_wr_data,
    output logic                  st_rd_en,
    output logic [AW-1:0]         st_rd_addr,
    input  logic [DATA_WIDTH-1:0] st_rd_data,

    output logic [AW:0]           level
);

    // One slot is kept free so the storage's own full flag can never assert.
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH - 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          m_valid_q;
    logic          last_grant;

    logic          grant;
    logic          can_wr;
    logic          wr_fire;
    logic          rd_fire;

    // Grant selection: a lone requester always wins; on a tie the requester
    // that did not win the last accepted write goes next.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // can_wr uses the registered count, so a read firing in the same cycle
    // does not open a slot for a write at full occupancy. Gating with rst_n
    // keeps every handshake and storage enable quiet while reset is held.
    always_comb begin
        can_wr     = rst_n && (count < CAP);
        req0_ready = can_wr && !grant;
        req1_ready = can_wr &&  grant;
        wr_fire    = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);

        // Issue a storage read whenever there is data and the output slot is
        // either empty or being emptied this cycle; this gives 1 word/cycle.
        rd_fire    = rst_n && (count != '0) && (!m_valid_q || m_ready);

        st_wr_en   = wr_fire;
        st_wr_addr = wr_ptr;
        st_wr_data = grant ? req1_data : req0_data;

        st_rd_en   = rd_fire;
        st_rd_addr = rd_ptr;

        m_valid    = m_valid_q;
        m_data     = st_rd_data;
        level      = count;
    end

    // Pointers, occupancy, arbitration history and the read-port valid flag.
    // m_valid tracks the storage output register: it is set the cycle after a
    // read is issued and drops only when the consumer takes the word without
    // a replacement read being issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            m_valid_q  <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (wr_fire) begin
                wr_ptr     <= wr_ptr + AW'(1);
                last_grant <= grant;
            end

            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (rd_fire) begin
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl
// Self-checking bench for fifo_arb_ctrl. A behavioural model of the 64x16
// storage (registered read, contents not cleared by reset) is attached to the
// storage ports. Expected output words are pushed into a queue by the
// stimulus; an independent monitor pops and compares on every read-port
// handshake. Cycle-exact expectations (readies, addresses, level) are checked
// directly by the stimulus.
module tb_fifo_arb_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          st_wr_en;
    logic [AW-1:0] st_wr_addr;
    logic [DW-1:0] st_wr_data;
    logic          st_rd_en;
    logic [AW-1:0] st_rd_addr;
    logic [DW-1:0] st_rd_data;
    logic [AW:0]   level;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] expQ [$];
    int            nChecks = 0;
    int            nFail   = 0;
    int            rdCount;

    fifo_arb_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .st_wr_en   (st_wr_en),
        .st_wr_addr (st_wr_addr),
        .st_wr_data (st_wr_data),
        .st_rd_en   (st_rd_en),
        .st_rd_addr (st_rd_addr),
        .st_rd_data (st_rd_data),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Storage model: synchronous write, registered read that holds its
    // output when no read is issued.
    always @(posedge clk) begin
        if (st_wr_en) mem[st_wr_addr] <= st_wr_data;
        if (st_rd_en) st_rd_data <= mem[st_rd_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read-port handshake must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL unexpected output: got 0x%0h, expected no word", m_data);
            end else begin
                checkOutput("m_data order", m_data, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic v0, input logic [63:0] d0,
                                 input logic v1, input logic [63:0] d1,
                                 input logic mr);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        m_ready    = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic waitDrain(input string name);
        for (int b = 0; b < 200; b++) begin
            if (expQ.size() == 0) break;
            tick();
        end
        checkOutput(name, 64'(expQ.size()), 64'h0);
        expQ.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset behaviour: readies and enables stay low even with valid requests.
        rst_n = 1'b0;
        applyStimulus(1'b1, 64'h1, 1'b1, 64'h2, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("reset req0_ready", req0_ready, 1'b0);
        checkOutput("reset req1_ready", req1_ready, 1'b0);
        checkOutput("reset st_wr_en", st_wr_en, 1'b0);
        checkOutput("reset st_rd_en", st_rd_en, 1'b0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        checkOutput("reset level", level, 5'd0);
        checkOutput("reset m_valid", m_valid, 1'b0);
        tick();

        // Fill from req0 with the consumer stalled. One word moves into the
        // output register, so 16 writes are accepted before level reaches 15.
        for (int i = 0; i < 16; i++) expQ.push_back(64'(i));
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(1'b1, 64'(i), 1'b0, 64'h0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("fill req0_ready c%0d", i), req0_ready, (i <= 15));
            if (i <= 15) checkOutput($sformatf("fill st_wr_addr c%0d", i), st_wr_addr, 64'(i));
            if (i == 1) checkOutput("fill m_valid early", m_valid, 1'b0);
            if (i == 2) begin
                checkOutput("fill m_valid first", m_valid, 1'b1);
                checkOutput("fill m_data first", m_data, 64'h0);
            end
            tick();
        end

        // Full boundary: a read fires at level 15 but the write still stalls.
        applyStimulus(1'b0, 64'h0, 1'b1, 64'h55, 1'b1);
        @(negedge clk);
        checkOutput("full level", level, 5'd15);
        checkOutput("full req1_ready", req1_ready, 1'b0);
        checkOutput("full st_rd_en", st_rd_en, 1'b1);
        tick();
        @(negedge clk);
        checkOutput("full+1 level", level, 5'd14);
        checkOutput("full+1 req1_ready", req1_ready, 1'b1);
        expQ.push_back(64'h55);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        waitDrain("fill drain leftover");

        // Contention: grants alternate starting with req0 after reset.
        applyReset();
        for (int j = 0; j < 4; j++) begin
            expQ.push_back(64'h100 + 64'(j));
            expQ.push_back(64'h200 + 64'(j));
        end
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 64'h100 + 64'(j / 2), 1'b1, 64'h200 + 64'(j / 2), 1'b1);
            @(negedge clk);
            checkOutput($sformatf("rr req0_ready c%0d", j), req0_ready, (j % 2 == 0));
            checkOutput($sformatf("rr req1_ready c%0d", j), req1_ready, (j % 2 == 1));
            tick();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        waitDrain("contention drain leftover");

        // Backpressure: three words, consumer stalled; only one read issued
        // and the output word holds steady.
        applyReset();
        rdCount = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 64'h0, (k < 3), 64'hA0 + 64'(k), 1'b0);
            @(negedge clk);
            rdCount += int'(st_rd_en);
            if (k >= 2) begin
                checkOutput($sformatf("bp m_valid c%0d", k), m_valid, 1'b1);
                checkOutput($sformatf("bp m_data hold c%0d", k), m_data, 64'hA0);
            end
            tick();
        end
        checkOutput("bp read issue count", 64'(rdCount), 64'd1);
        expQ.push_back(64'hA0);
        expQ.push_back(64'hA1);
        expQ.push_back(64'hA2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("bp release m_valid c%0d", k), m_valid, (k < 3));
            tick();
        end
        waitDrain("backpressure drain leftover");

        // Wrap: 40 words streamed, both addresses wrap 15->0 twice.
        applyReset();
        for (int i = 0; i < 40; i++) expQ.push_back(64'h300 + 64'(i));
        for (int i = 0; i <= 40; i++) begin
            applyStimulus((i < 40), 64'h300 + 64'(i), 1'b0, 64'h0, 1'b1);
            @(negedge clk);
            if (i < 40) begin
                checkOutput($sformatf("wrap req0_ready c%0d", i), req0_ready, 1'b1);
                checkOutput($sformatf("wrap st_wr_addr c%0d", i), st_wr_addr, 64'(i % 16));
            end
            if (i >= 1) begin
                checkOutput($sformatf("wrap st_rd_en c%0d", i), st_rd_en, 1'b1);
                checkOutput($sformatf("wrap st_rd_addr c%0d", i), st_rd_addr, 64'((i - 1) % 16));
            end
            tick();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
        waitDrain("wrap drain leftover");

        // Reset mid-operation with level 7 and a word pending on the port.
        applyReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 64'h400 + 64'(k), 1'b0, 64'h0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        checkOutput("midop level", level, 5'd7);
        checkOutput("midop m_valid", m_valid, 1'b1);
        tick();
        rst_n = 1'b0;
        applyStimulus(1'b1, 64'h999, 1'b1, 64'h999, 1'b0);
        @(negedge clk);
        checkOutput("midop rst req0_ready", req0_ready, 1'b0);
        checkOutput("midop rst req1_ready", req1_ready, 1'b0);
        checkOutput("midop rst st_wr_en", st_wr_en, 1'b0);
        checkOutput("midop rst st_rd_en", st_rd_en, 1'b0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        checkOutput("post-rst m_valid", m_valid, 1'b0);
        checkOutput("post-rst level", level, 5'd0);
        checkOutput("post-rst wr addr", st_wr_addr, 4'd0);
        checkOutput("post-rst rd addr", st_rd_addr, 4'd0);
        tick();
        @(negedge clk);
        checkOutput("post-rst m_valid stays low", m_valid, 1'b0);
        checkOutput("post-rst st_rd_en idle", st_rd_en, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
